instmem_server: RTL

INSTMEM_SERVER -- requirements
Module: instmem_server

---
 rtl/instmem_server.sv | 129 ++++++++++++
 1 files changed

// File: rtl/instmem_server.sv
// Instruction memory server: a word-addressable program store that refills
// whole cache lines. The line is read one word per cycle, then presented on a
// valid/ready response port until the cache takes it. The store is loaded
// through a simple word-write port that is only honoured while idle.
module instmem_server #(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    input  logic [31:0]                req_addr,
    output logic                       req_ready,
    output logic                       resp_valid,
    output logic [32*LINE_WORDS-1:0]   resp_line,
    output logic [31:0]                resp_addr,
    input  logic                       resp_ready,
    input  logic                       wr_en,
    input  logic [31:0]                wr_addr,
    input  logic [31:0]                wr_data,
    output logic                       wr_ready
);

    // Word index width, beat counter width and byte offset width of a line
    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W  = BEAT_W + 2;
    localparam int unsigned LINE_W = 32 * LINE_WORDS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    state_e              state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic                ready_q;
    logic                resp_valid_q;
    logic [LINE_W-1:0]   line_q;
    logic [31:0]         base_q;

    // Program store; deliberately has no reset so code survives a reset pulse
    logic [31:0]         mem_q [MEM_WORDS];

    logic [IDX_W-1:0]    wr_idx_s;
    logic [IDX_W-1:0]    rd_idx_s;
    logic [31:0]         rd_word_s;
    logic                wr_fire_s;
    logic                unused_addr_bits_s;

    // Address bits above the store size are dropped, so indices wrap naturally
    assign wr_idx_s  = wr_addr[IDX_W+1:2];
    assign rd_idx_s  = base_q[IDX_W+1:2] + IDX_W'(beat_q);
    assign rd_word_s = mem_q[rd_idx_s];

    // Writes are only legal while idle; a write on the accepting edge still
    // lands before the first fetch beat reads the store.
    assign wr_fire_s = wr_en && (state_q == ST_IDLE);

    // Low offset bits and upper address bits carry no information here
    assign unused_addr_bits_s = ^{req_addr[OFF_W-1:0], wr_addr[31:IDX_W+2], wr_addr[1:0]};

    assign req_ready  = ready_q;
    assign wr_ready   = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_line  = line_q;
    assign resp_addr  = base_q;

    // Store write port: one word per cycle from the program loader
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_q[wr_idx_s] <= wr_data;
        end
    end

    // Refill controller: accept a request, gather the line beat by beat, then
    // hold the response until the cache consumes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            line_q       <= '0;
            base_q       <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        base_q  <= {req_addr[31:OFF_W], {OFF_W{1'b0}}};
                        beat_q  <= '0;
                        ready_q <= 1'b0;
                        state_q <= ST_FETCH;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    line_q[{beat_q, 5'b00000} +: 32] <= rd_word_s;
                    if (beat_q == BEAT_W'(LINE_WORDS - 1)) begin
                        beat_q       <= '0;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                ST_RESP: begin
                    // Line and address stay frozen until the handshake
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        ready_q      <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else begin
                        resp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    beat_q       <= '0;
                    resp_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
